// File: rtl/temporal_pkg.sv
// temporal_pkg: shared types for the not-equal temporal channel array
package temporal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_B_SEEN,
        ST_FIRE,
        ST_HOLD,
        ST_INHIBIT
    } ne_state_t;

    typedef enum logic {
        MODE_PULSE,
        MODE_LEVEL
    } ne_mode_t;

endpackage

// File: rtl/ne_channel.sv
// ne_channel: one not-equal channel; fires on a unless a and b arrive together
module ne_channel
    import temporal_pkg::*;
#(
    parameter int PULSE_WIDTH = 8
) (
    input  logic aclk,
    input  logic grst_n,
    input  logic set,
    input  logic gend,
    input  logic level,
    input  logic a,
    input  logic b,
    output logic y,
    output logic fired
);

    localparam int CW = $clog2(PULSE_WIDTH + 1);

    ne_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // next state: restart beats gamma end, which beats normal channel transitions
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (set) begin
            state_d = ST_ARMED;
            cnt_d   = '0;
        end else if (gend) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (a)
                        state_d = b ? ST_INHIBIT : ST_FIRE;
                    else if (b)
                        state_d = ST_B_SEEN;
                    cnt_d = '0;
                end
                ST_B_SEEN: begin
                    if (a)
                        state_d = ST_FIRE;
                    cnt_d = '0;
                end
                ST_FIRE: begin
                    cnt_d = (cnt_q == CW'(PULSE_WIDTH)) ? cnt_q : cnt_q + 1'b1;
                    if (!level && cnt_q == CW'(PULSE_WIDTH - 1))
                        state_d = ST_HOLD;
                end
                default: ;
            endcase
        end
    end

    // channel state and pulse counter registers
    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign y     = (state_q == ST_FIRE);
    assign fired = (state_q == ST_FIRE) || (state_q == ST_HOLD);

endmodule

// File: rtl/ne_temporal_array.sv
// ne_temporal_array: gamma-cycle sequencer driving an array of not-equal channels
module ne_temporal_array
    import temporal_pkg::*;
#(
    parameter int NUM_CH            = 4,
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int GAMMA_CYCLE_LEN   = 16,
    parameter int PULSE_WIDTH       = 8
) (
    input  logic              aclk,
    input  logic              grst_n,
    input  logic              set,
    input  logic              pulse_mode,
    input  logic [NUM_CH-1:0] a,
    input  logic [NUM_CH-1:0] b,
    output logic [NUM_CH-1:0] y,
    output logic              active,
    output logic              done,
    output logic [NUM_CH-1:0] fired
);

    localparam logic [GAMMA_CYCLE_WIDTH-1:0] LAST = GAMMA_CYCLE_WIDTH'(GAMMA_CYCLE_LEN - 1);

    logic [GAMMA_CYCLE_WIDTH-1:0] cnt_q, cnt_d;
    logic                         active_q, active_d;
    ne_mode_t                     mode_q, mode_d;
    logic [NUM_CH-1:0]            fired_q, fired_d;
    logic [NUM_CH-1:0]            fired_ch;

    // gamma sequencing; a set on the last cycle restarts instead of completing
    always_comb begin
        done     = active_q && (cnt_q == LAST) && !set;
        active_d = set || (active_q && !done);
        cnt_d    = (set || done) ? '0 : active_q ? cnt_q + 1'b1 : cnt_q;
        mode_d   = set ? (pulse_mode ? MODE_PULSE : MODE_LEVEL) : mode_q;
        fired_d  = done ? fired_ch : fired_q;
    end

    // gamma counter, open flag, captured mode and fired summary
    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            mode_q   <= MODE_PULSE;
            fired_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            mode_q   <= mode_d;
            fired_q  <= fired_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ne_channel #(
            .PULSE_WIDTH(PULSE_WIDTH)
        ) u_ch (
            .aclk  (aclk),
            .grst_n(grst_n),
            .set   (set),
            .gend  (done),
            .level (mode_q == MODE_LEVEL),
            .a     (a[i]),
            .b     (b[i]),
            .y     (y[i]),
            .fired (fired_ch[i])
        );
    end

    assign active = active_q;
    assign fired  = fired_q;

endmodule
